// File: rtl/seg7_pkg.sv
// Shared seven-segment pattern table (abc_defg order, bit 6 = a, bit 0 = g).
// The encoder and decoder sides both use these constants.
package seg7_pkg;

  localparam int SEG7_W = 7;

  typedef logic [SEG7_W-1:0] seg7_t;

  localparam seg7_t SEG7_HEX_0 = 7'h7E;
  localparam seg7_t SEG7_HEX_1 = 7'h30;
  localparam seg7_t SEG7_HEX_2 = 7'h6D;
  localparam seg7_t SEG7_HEX_3 = 7'h79;
  localparam seg7_t SEG7_HEX_4 = 7'h33;
  localparam seg7_t SEG7_HEX_5 = 7'h5B;
  localparam seg7_t SEG7_HEX_6 = 7'h5F;
  localparam seg7_t SEG7_HEX_7 = 7'h70;
  localparam seg7_t SEG7_HEX_8 = 7'h7F;
  localparam seg7_t SEG7_HEX_9 = 7'h73;
  localparam seg7_t SEG7_HEX_A = 7'h77;
  localparam seg7_t SEG7_HEX_B = 7'h1F;
  localparam seg7_t SEG7_HEX_C = 7'h4E;
  localparam seg7_t SEG7_HEX_D = 7'h3D;
  localparam seg7_t SEG7_HEX_E = 7'h4F;
  localparam seg7_t SEG7_HEX_F = 7'h47;

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational inverse of the hex-to-seven-segment table.
// valid is low for any pattern outside the sixteen hex glyphs.
module seven_segment_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [SEG7_W-1:0] pattern,
  output logic [3:0]        nibble,
  output logic              valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b1;
    case (pattern)
      SEG7_HEX_0: nibble = 4'h0;
      SEG7_HEX_1: nibble = 4'h1;
      SEG7_HEX_2: nibble = 4'h2;
      SEG7_HEX_3: nibble = 4'h3;
      SEG7_HEX_4: nibble = 4'h4;
      SEG7_HEX_5: nibble = 4'h5;
      SEG7_HEX_6: nibble = 4'h6;
      SEG7_HEX_7: nibble = 4'h7;
      SEG7_HEX_8: nibble = 4'h8;
      SEG7_HEX_9: nibble = 4'h9;
      SEG7_HEX_A: nibble = 4'hA;
      SEG7_HEX_B: nibble = 4'hB;
      SEG7_HEX_C: nibble = 4'hC;
      SEG7_HEX_D: nibble = 4'hD;
      SEG7_HEX_E: nibble = 4'hE;
      SEG7_HEX_F: nibble = 4'hF;
      default: begin
        nibble = 4'h0;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_reader.sv
// Recovers the hex value shown on a multiplexed seven-segment bus: debounces
// each digit dwell, decodes it into a slot, and publishes a frame once all digits are seen.
module seven_segment_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEG7_W-1:0]       seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic [NUM_DIGITS-1:0]   digit_err
);

  localparam int         SAMPLE_W = SEG7_W + NUM_DIGITS;
  localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_ARM  = 4'(STABLE_CYCLES - 1);

  logic [SAMPLE_W-1:0]     sample;
  logic [3:0]              cnt;
  logic                    dwell_done;
  logic [4*NUM_DIGITS-1:0] slots, slots_nxt;
  logic [NUM_DIGITS-1:0]   captured, captured_nxt;
  logic [NUM_DIGITS-1:0]   err, err_nxt;
  logic [3:0]              nibble;
  logic                    nibble_valid;
  logic                    same, one_hot, capture, frame_done;

  seven_segment_pattern_decoder u_decoder (
    .pattern (seg_in),
    .nibble  (nibble),
    .valid   (nibble_valid)
  );

  assign same       = ({seg_in, digit_sel} == sample);
  assign one_hot    = ($countones(digit_sel) == 1);
  assign capture    = same && (cnt == CNT_ARM) && one_hot && !dwell_done;
  assign frame_done = capture && (&captured_nxt);

  // Next slot/error/captured state including the digit captured at this edge.
  always_comb begin
    slots_nxt    = slots;
    err_nxt      = err;
    captured_nxt = captured;
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_sel[i]) begin
          slots_nxt[4*i +: 4] = nibble_valid ? nibble : 4'h0;
          err_nxt[i]          = ~nibble_valid;
        end
      end
      captured_nxt = captured | digit_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample     <= '0;
      cnt        <= '0;
      dwell_done <= 1'b0;
    end else begin
      sample <= {seg_in, digit_sel};
      if (!same) begin
        cnt        <= 4'd1;
        dwell_done <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 4'd1;
        if (capture) dwell_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots       <= '0;
      captured    <= '0;
      err         <= '0;
      value_out   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      digit_err   <= '0;
    end else begin
      slots       <= slots_nxt;
      frame_valid <= frame_done;
      if (frame_done) begin
        value_out <= slots_nxt;
        digit_err <= err_nxt;
        frame_err <= |err_nxt;
        captured  <= '0;
        err       <= '0;
      end else begin
        captured <= captured_nxt;
        err      <= err_nxt;
      end
    end
  end

endmodule

// File: doc/seven_segment_scan_reader.md
Name: seven_segment_scan_reader

Overview:
- Receive-side counterpart of the team's hex-to-seven-segment decoders. Monitors a multiplexed seven-segment display bus (segment lines plus one-hot digit selects) and recovers the displayed hexadecimal value.
- Debounces each digit dwell, inverse-decodes segment patterns to nibbles, and assembles a full frame once every digit has been captured.
- Used as a display-bus checker and loopback monitor in board-level test designs.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; width of digit_sel.
- STABLE_CYCLES, 3: consecutive identical samples required before a capture (legal range 2..15).

Ports:
- clk, in, 1: system clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- seg_in, in, 7: segment lines in abc_defg order, bit 6 = a, bit 0 = g, active-high.
- digit_sel, in, NUM_DIGITS: one-hot digit enable, active-high; bit i selects digit i.
- value_out, out, 4*NUM_DIGITS: last completed frame; digit i occupies bits [4i+3:4i].
- frame_valid, out, 1: single-cycle pulse when value_out updates.
- frame_err, out, 1: at least one digit in the last completed frame had an unrecognised pattern; held until the next frame completes.
- digit_err, out, NUM_DIGITS: per-digit error flags of the last completed frame; held like frame_err.

Behaviour:
- Reset, asynchronous:
  - value_out = 0, frame_valid = 0, frame_err = 0, digit_err = 0.
  - Internal state cleared: sample register, stability counter, slot registers, captured mask, error mask, dwell-captured flag.
  - Reset asserted mid-frame discards all partial captures.
- Stability tracking, each edge:
  - If {seg_in, digit_sel} equals the previous sample, cnt <= cnt+1, saturating at STABLE_CYCLES.
  - Otherwise cnt <= 1 and the dwell-captured flag is cleared.
  - The previous-sample register always loads the current inputs.
- Capture condition: at the edge where cnt advances from STABLE_CYCLES-1 to STABLE_CYCLES, and digit_sel is exactly one-hot.
  - With inputs held before edges E1, E2, E3 and STABLE_CYCLES=3, the capture happens at E3.
  - At most one capture per dwell; a held input never re-captures.
- digit_sel all-zero (blanking) or multi-hot: never captures; the counter still runs.
- Capture action for selected digit i:
  - The pattern is inverse-decoded: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 73->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F.
  - Match: slot[i] <= nibble, err[i] <= 0.
  - No match: slot[i] <= 0, err[i] <= 1.
  - In both cases captured[i] <= 1.
  - Re-capturing a digit already captured in the current frame overwrites it (latest wins).
- Frame completion: when a capture makes captured all-ones, at that same edge:
  - value_out <= assembled slots, including the just-captured nibble.
  - digit_err <= err mask, including the new bit; frame_err <= OR of that mask.
  - frame_valid <= 1 for exactly one cycle.
  - captured and err masks are cleared, so the next frame starts empty at that edge.
- frame_valid is 0 on all other cycles.
- Latency: frame_valid is high in the cycle following the capturing edge of the final digit.
- Digit capture order is arbitrary; frames need not follow scan order.

Decomposition:
- Package seg7_pkg holds:
  - SEG7_W = 7.
  - The sixteen pattern constants SEG7_HEX_0 .. SEG7_HEX_F in abc_defg order.
  - A typedef for the 7-bit pattern.
- These constants are shared with the existing encoder side, so encode and decode tables cannot diverge.
- Sub-module seven_segment_pattern_decoder: purely combinational.
  - Input: 7-bit pattern.
  - Outputs: 4-bit nibble and a 1-bit valid.
  - Instantiated once, on seg_in.

Test Plan:
- Reset then idle: reset pulse with random inputs, blank digit_sel -> value_out=0, frame_valid never asserts, digit_err=0.
- Clean frame: each dwell held 4 cycles:
  - Stimulus: sel 1000/30, 0100/6D, 0010/77, 0001/47.
  - Response: one frame_valid pulse, value_out=16'h12AF, frame_err=0.
- Debounce: sel 0001 with pattern 7F held only 2 cycles, alternating with 5F, never 3 stable -> no capture and no frame.
  - Then 7F held 3 cycles -> digit 0 captured at the third edge.
- Invalid pattern: one digit driven 7'h00 with sel 0100, others valid -> frame_valid pulses, frame_err=1, digit_err=4'b0100, value_out[11:8]=0.
- Overwrite and order: capture order 0001, 0001 (new value), 1000, 0010, 0100 -> a single frame, with the second value for digit 0.
  - Held dwells produce no extra captures.
- Reset mid-frame: assert reset after 2 of 4 digits are captured, then run a full 4-digit frame -> exactly one frame_valid, with only the post-reset values.
